// File: rtl/dac_frame_builder_if.sv
// Sample write channel into the DAC frame builder: valid/ready handshake
// carrying a 2-bit channel tag and a 12-bit unsigned sample.
interface dac_frame_builder_if;
   logic        s_valid;
   logic        s_ready;
   logic [1:0]  s_chan;
   logic [11:0] s_data;

   modport master (output s_valid, output s_chan, output s_data, input s_ready);
   modport slave  (input s_valid, input s_chan, input s_data, output s_ready);
endinterface

// File: rtl/dac_frame_builder.sv
// Buffers tagged DAC samples in a small FIFO and presents them as a 32-bit command frame
// (word1/word2) that only changes in the slot before the serializer load. Option: DAC_IDLE_NOP_EN.
module dac_frame_builder #(
   parameter int         FRAME_PERIOD = 64,
   parameter int         FIFO_DEPTH   = 4,
   parameter logic [3:0] CMD_WRITE    = 4'b0011
) (
   input  logic                          clk,
   input  logic                          reset,
   dac_frame_builder_if.slave            s,
   output logic [15:0]                   word1,
   output logic [15:0]                   word2,
   output logic                          frame_tick,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int PH_W  = $clog2(FRAME_PERIOD);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LVL_W = AW + 1;

   logic [PH_W-1:0]  phase;
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [LVL_W-1:0] level;
   logic [13:0]      mem [FIFO_DEPTH];
   logic [13:0]      head;
   logic             full;
   logic             empty;
   logic             slot;
   logic             push;
   logic             pop;

   function automatic logic [15:0] fmt_word1(input logic [1:0] chan);
      return {8'h00, CMD_WRITE, 2'b00, chan};
   endfunction

   function automatic logic [15:0] fmt_word2(input logic [11:0] data);
      return {data, 4'h0};
   endfunction

   // Extra pointer bit makes the pointer difference the true occupancy.
   assign level      = wr_ptr - rd_ptr;
   assign full       = (level == LVL_W'(FIFO_DEPTH));
   assign empty      = (level == '0);
   assign fifo_level = level;
   assign s.s_ready  = !full;

   assign slot = (phase == PH_W'(FRAME_PERIOD - 1));
   assign push = s.s_valid && !full;
   assign pop  = slot && !empty;
   assign head = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase      <= '0;
         frame_tick <= 1'b0;
      end else begin
         phase      <= slot ? '0 : phase + 1'b1;
         frame_tick <= slot;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {s.s_chan, s.s_data};
   end

   // Words move only on the update-slot edge, so they are stable through the load edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word1 <= '0;
         word2 <= '0;
      end else if (pop) begin
         word1 <= fmt_word1(head[13:12]);
         word2 <= fmt_word2(head[11:0]);
      end
`ifdef DAC_IDLE_NOP_EN
      else if (slot) begin
         word1 <= 16'h00FF;
         word2 <= 16'h0000;
      end
`endif
   end

endmodule

// File: tb/tb_dac_frame_builder.sv
// Scoreboard bench for dac_frame_builder: accepted samples are queued with their accept
// cycle and checked against word1/word2 at each update slot. Honours DAC_IDLE_NOP_EN.
module tb_dac_frame_builder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] word1;
   logic [15:0] word2;
   logic        frame_tick;
   logic [2:0]  fifo_level;

   dac_frame_builder_if s_if ();

   dac_frame_builder dut (
      .clk        (clk),
      .reset      (reset),
      .s          (s_if),
      .word1      (word1),
      .word2      (word2),
      .frame_tick (frame_tick),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] w1;
      logic [15:0] w2;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_mis = 0;
   int          cyc;
   logic [15:0] exp_w1;
   logic [15:0] exp_w2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Cycle index since reset release equals the DUT phase (mod 64).
   always @(posedge clk or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if ((cyc % 64) == 0 && cyc > 0) begin
            if (sb.size() > 0 && sb[0].cyc < cyc - 1) begin
               exp_w1 = sb[0].w1;
               exp_w2 = sb[0].w2;
               void'(sb.pop_front());
            end else begin
`ifdef DAC_IDLE_NOP_EN
               exp_w1 = 16'h00FF;
               exp_w2 = 16'h0000;
`endif
            end
         end
         check("frame_tick", {31'd0, frame_tick}, {31'd0, ((cyc % 64) == 0 && cyc > 0)});
         check("word1", {16'd0, word1}, {16'd0, exp_w1});
         check("word2", {16'd0, word2}, {16'd0, exp_w2});
      end
   end

   task automatic wait_cyc(input int n);
      int k = 0;
      while (cyc != n && k < 1000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 1000) check("wait_timeout", 32'd0, 32'd1);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
      exp_w1 = 16'h0000;
      exp_w2 = 16'h0000;
      s_if.s_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_word1", {16'd0, word1}, 32'h0000);
      check("rst_word2", {16'd0, word2}, 32'h0000);
      check("rst_tick", {31'd0, frame_tick}, 32'd0);
      check("rst_ready", {31'd0, s_if.s_ready}, 32'd1);
      check("rst_level", {29'd0, fifo_level}, 32'd0);
      #1 reset = 1'b1;
   endtask

   task automatic push(input logic [1:0] ch, input logic [11:0] d, output int acc);
      int n = 0;
      exp_t e;
      s_if.s_valid = 1'b1;
      s_if.s_chan  = ch;
      s_if.s_data  = d;
      while (s_if.s_ready !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         check("push_timeout", 32'd0, 32'd1);
         acc = -1;
      end else begin
         acc   = cyc;
         e.w1  = {8'h00, 4'b0011, 2'b00, ch};
         e.w2  = {d, 4'h0};
         e.cyc = cyc;
         sb.push_back(e);
      end
      @(negedge clk);
      s_if.s_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      reset        = 1'b0;
      s_if.s_valid = 1'b0;
      s_if.s_chan  = 2'd0;
      s_if.s_data  = 12'd0;
      exp_w1       = 16'h0000;
      exp_w2       = 16'h0000;

      // Idle for two frame periods.
      apply_reset();
      wait_cyc(130);
      check("idle_ready", {31'd0, s_if.s_ready}, 32'd1);
      check("idle_level", {29'd0, fifo_level}, 32'd0);

      // Single sample, latency to the first slot.
      apply_reset();
      wait_cyc(10);
      push(2'd2, 12'hABC, acc);
      check("single_level1", {29'd0, fifo_level}, 32'd1);
      wait_cyc(64);
      check("single_w1", {16'd0, word1}, 32'h0032);
      check("single_w2", {16'd0, word2}, 32'hABC0);
      check("single_level0", {29'd0, fifo_level}, 32'd0);
      wait_cyc(130);
      check("single_sb_empty", sb.size(), 32'd0);

      // Six back-to-back samples against a depth-4 FIFO.
      apply_reset();
      wait_cyc(5);
      for (int i = 0; i < 6; i++) begin
         push(2'(i), 12'(12'h100 * (i + 1) + i), acc);
         if (i == 3) begin
            check("burst_acc4", acc, 32'd8);
            check("burst_full_ready", {31'd0, s_if.s_ready}, 32'd0);
            check("burst_full_level", {29'd0, fifo_level}, 32'd4);
         end
         if (i == 4) check("burst_acc5", acc, 32'd64);
         if (i == 5) check("burst_acc6", acc, 32'd128);
      end
      wait_cyc(400);
      check("burst_sb_empty", sb.size(), 32'd0);

      // Push landing on the update-slot edge waits for the next slot.
      apply_reset();
      wait_cyc(63);
      push(2'd1, 12'h555, acc);
      check("slot_push_acc", acc, 32'd63);
      check("slot_push_w1", {16'd0, word1}, 32'h0000);
      wait_cyc(128);
      check("slot_push_w1b", {16'd0, word1}, 32'h0031);
      check("slot_push_w2b", {16'd0, word2}, 32'h5550);

      // Empty slot after a write: hold or no-op frame.
      apply_reset();
      wait_cyc(10);
      push(2'd0, 12'h123, acc);
      wait_cyc(70);
      check("empty_w1_a", {16'd0, word1}, 32'h0030);
      check("empty_w2_a", {16'd0, word2}, 32'h1230);
      wait_cyc(130);
`ifdef DAC_IDLE_NOP_EN
      check("empty_w1_b", {16'd0, word1}, 32'h00FF);
      check("empty_w2_b", {16'd0, word2}, 32'h0000);
`else
      check("empty_w1_b", {16'd0, word1}, 32'h0030);
      check("empty_w2_b", {16'd0, word2}, 32'h1230);
`endif

      // Reset mid-operation with queued samples.
      apply_reset();
      wait_cyc(5);
      for (int i = 0; i < 3; i++) push(2'd3, 12'(12'hF00 + i), acc);
      wait_cyc(40);
      check("midrst_level_pre", {29'd0, fifo_level}, 32'd3);
      #2 reset = 1'b0;
      sb.delete();
      exp_w1 = 16'h0000;
      exp_w2 = 16'h0000;
      #1;
      check("midrst_w1", {16'd0, word1}, 32'h0000);
      check("midrst_w2", {16'd0, word2}, 32'h0000);
      check("midrst_level", {29'd0, fifo_level}, 32'd0);
      check("midrst_ready", {31'd0, s_if.s_ready}, 32'd1);
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;
      wait_cyc(1);
      check("midrst_level_post", {29'd0, fifo_level}, 32'd0);
      wait_cyc(200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
